// File: rtl/arith_pkg.sv
// Shared opcode definitions for the registered arithmetic unit.
package arith_pkg;

  typedef logic [1:0] arith_op_t;

  localparam arith_op_t OP_ADD = 2'd0;
  localparam arith_op_t OP_SUB = 2'd1;
  localparam arith_op_t OP_MUL = 2'd2;
  localparam arith_op_t OP_DIV = 2'd3;

endpackage

// File: rtl/arith_if.sv
// Operand/opcode/result bundle between a requester and arith_operations.
// No handshake: the slave samples A/B/sel on every rising clk and presents C/rem one edge later.
import arith_pkg::*;

interface arith_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  arith_op_t          sel;
  logic [2*WIDTH-1:0] C;
  logic [WIDTH-1:0]   rem;

  modport master (output A, output B, output sel, input C, input rem);
  modport slave  (input A, input B, input sel, output C, output rem);
endinterface

// File: rtl/arith_divider.sv
// Combinational restoring divider: WIDTH shift/compare/subtract stages, MSB first.
import arith_pkg::*;

module arith_divider #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;

  always_comb begin
    r = '0;
    q = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      // Partial remainder is one bit wider so the shifted-in bit never overflows.
      r = {r[WIDTH-1:0], a[i]};
      if (r >= {1'b0, b}) begin
        r    = r - {1'b0, b};
        q[i] = 1'b1;
      end
    end
  end

  assign dbz       = (b == '0);
  assign quotient  = dbz ? '1 : q;
  assign remainder = dbz ? a  : r[WIDTH-1:0];

endmodule

// File: rtl/arith_operations.sv
// Registered add/sub/mul/div unit with one-cycle latency.
// Define ARITH_DBZ_FLAG_EN to add a registered divide-by-zero flag output (dbz).
import arith_pkg::*;

module arith_operations #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  arith_if.slave   bus
`ifdef ARITH_DBZ_FLAG_EN
  ,
  output logic     dbz
`endif
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;
  logic               div_dbz;
  logic [2*WIDTH-1:0] c_next;
  logic [WIDTH-1:0]   rem_next;

  assign a_ext = {{WIDTH{1'b0}}, bus.A};
  assign b_ext = {{WIDTH{1'b0}}, bus.B};

  arith_divider #(.WIDTH(WIDTH)) u_div (
    .a         (bus.A),
    .b         (bus.B),
    .quotient  (div_q),
    .remainder (div_r),
    .dbz       (div_dbz)
  );

  always_comb begin
    c_next   = '0;
    rem_next = '0;
    case (bus.sel)
      OP_ADD: c_next = a_ext + b_ext;
      OP_SUB: c_next = a_ext - b_ext;
      OP_MUL: c_next = a_ext * b_ext;
      OP_DIV: begin
        // A zero divisor reports all ones across the full result width.
        c_next   = div_dbz ? '1 : {{WIDTH{1'b0}}, div_q};
        rem_next = div_r;
      end
      default: c_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.C   <= '0;
      bus.rem <= '0;
    end else begin
      bus.C   <= c_next;
      bus.rem <= rem_next;
    end
  end

`ifdef ARITH_DBZ_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dbz <= 1'b0;
    else     dbz <= (bus.sel == OP_DIV) && div_dbz;
  end
`endif

endmodule

// File: tb/tb_arith_operations.sv
// Directed, table-driven bench for arith_operations (WIDTH=8), plus reset corner sequences.
import arith_pkg::*;

module tb_arith_operations;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
`ifdef ARITH_DBZ_FLAG_EN
  logic dbz;
`endif

  arith_if #(.WIDTH(WIDTH)) bus ();

  arith_operations #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARITH_DBZ_FLAG_EN
    ,
    .dbz (dbz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;      // wider than the port so truncation can be exercised
    logic [7:0]  b;
    logic [1:0]  sel;
    logic [15:0] exp_c;
    logic [7:0]  exp_rem;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs[$];
  int   n_tests;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] b, input logic [1:0] sel);
    bus.A   = a[7:0];
    bus.B   = b;
    bus.sel = sel;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive(16'd0, 8'd0, OP_ADD);

    vecs.push_back('{"add_small",   16'd2,    8'd3,   OP_ADD, 16'd5,     8'd0,   1'b0});
    vecs.push_back('{"add_carry",   16'd255,  8'd255, OP_ADD, 16'd510,   8'd0,   1'b0});
    vecs.push_back('{"sub_small",   16'd60,   8'd20,  OP_SUB, 16'd40,    8'd0,   1'b0});
    vecs.push_back('{"sub_borrow",  16'd3,    8'd5,   OP_SUB, 16'hFFFE,  8'd0,   1'b0});
    vecs.push_back('{"sub_0_255",   16'd0,    8'd255, OP_SUB, 16'hFF01,  8'd0,   1'b0});
    vecs.push_back('{"mul_small",   16'd10,   8'd9,   OP_MUL, 16'd90,    8'd0,   1'b0});
    vecs.push_back('{"mul_max",     16'd255,  8'd255, OP_MUL, 16'd65025, 8'd0,   1'b0});
    vecs.push_back('{"mul_zero",    16'd0,    8'd255, OP_MUL, 16'd0,     8'd0,   1'b0});
    vecs.push_back('{"div_100_39",  16'd100,  8'd39,  OP_DIV, 16'd2,     8'd22,  1'b0});
    vecs.push_back('{"div_0_7",     16'd0,    8'd7,   OP_DIV, 16'd0,     8'd0,   1'b0});
    vecs.push_back('{"div_by_zero", 16'd77,   8'd0,   OP_DIV, 16'hFFFF,  8'd77,  1'b1});
    vecs.push_back('{"div_255_1",   16'd255,  8'd1,   OP_DIV, 16'd255,   8'd0,   1'b0});
    vecs.push_back('{"div_200_201", 16'd200,  8'd201, OP_DIV, 16'd0,     8'd200, 1'b0});
    vecs.push_back('{"div_255_16",  16'd255,  8'd16,  OP_DIV, 16'd15,    8'd15,  1'b0});
    vecs.push_back('{"add_trunc",   16'd1300, 8'd230, OP_ADD, 16'd250,   8'd0,   1'b0});
    vecs.push_back('{"sub_zero_b",  16'd0,    8'd0,   OP_SUB, 16'd0,     8'd0,   1'b0});

    // Outputs held at zero under reset, across clock edges.
    #2;
    check("reset_c", 32'(bus.C), 32'd0);
    check("reset_rem", 32'(bus.rem), 32'd0);
`ifdef ARITH_DBZ_FLAG_EN
    check("reset_dbz", 32'(dbz), 32'd0);
`endif
    step();
    step();
    #2 rst = 1'b0;

    // Back-to-back vectors, one per cycle.
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].sel);
      step();
      check({vecs[i].name, "_c"}, 32'(bus.C), 32'(vecs[i].exp_c));
      check({vecs[i].name, "_rem"}, 32'(bus.rem), 32'(vecs[i].exp_rem));
`ifdef ARITH_DBZ_FLAG_EN
      check({vecs[i].name, "_dbz"}, 32'(dbz), 32'(vecs[i].exp_dbz));
`endif
    end

    // Asynchronous reset mid-run with C and rem nonzero.
    drive(16'd100, 8'd39, OP_DIV);
    step();
    check("pre_rst_c", 32'(bus.C), 32'd2);
    check("pre_rst_rem", 32'(bus.rem), 32'd22);
    drive(16'd77, 8'd0, OP_DIV);
    #2 rst = 1'b1;
    #1;
    check("async_rst_c", 32'(bus.C), 32'd0);
    check("async_rst_rem", 32'(bus.rem), 32'd0);
`ifdef ARITH_DBZ_FLAG_EN
    check("async_rst_dbz", 32'(dbz), 32'd0);
`endif
    drive(16'd2, 8'd3, OP_ADD);
    step();
    check("rst_held_c", 32'(bus.C), 32'd0);
    // Release between edges: outputs stay 0 until the next rising clk.
    #2 rst = 1'b0;
    #1;
    check("rst_released_c", 32'(bus.C), 32'd0);
    check("rst_released_rem", 32'(bus.rem), 32'd0);
    step();
    check("post_rst_add_c", 32'(bus.C), 32'd5);
    drive(16'd3, 8'd5, OP_SUB);
    step();
    check("post_rst_sub_c", 32'(bus.C), 32'hFFFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
